// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, VRAM geometry and the registered output bundle.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int SCALE     = 5;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int VRAM_COLS = 128;
    localparam int VRAM_ROWS = 96;
    localparam int VRAM_AW   = 14;

    typedef struct packed {
        logic               hsync_n;
        logic               vsync_n;
        logic               new_line;
        logic               new_frame;
        logic [VRAM_AW-1:0] vram_addr;
    } vga_out_t;

    localparam vga_out_t VGA_OUT_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, new_line: 1'b0,
                                         new_frame: 1'b0, vram_addr: '0};

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: free-running position counter with visible/sync decode.
module vga_axis_counter #(
    parameter int VISIBLE = 640,
    parameter int FP      = 16,
    parameter int SYNC    = 96,
    parameter int BP      = 48,
    parameter int W       = $clog2(VISIBLE + FP + SYNC + BP + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_n
);

    localparam int TOTAL = VISIBLE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
    localparam logic [W-1:0] SYNC_START = W'(VISIBLE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(VISIBLE + FP + SYNC);

    // advance one position per enable, wrapping after the last back-porch position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    assign wrap   = en && (count == LAST);
    assign active = (count < VIS_END);
    assign sync_n = !((count >= SYNC_START) && (count < SYNC_END));

endmodule

// File: rtl/vga_sync_timing_generator.sv
// Pixel-tick divider, H/V timing, 5x5 VRAM address scaling and output registers.
module vga_sync_timing_generator #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int SCALE     = vga_timing_pkg::SCALE,
    parameter int VRAM_COLS = vga_timing_pkg::VRAM_COLS
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic                                pixel_tick,
    output logic                                VGA_HSYNC,
    output logic                                VGA_VSYNC,
    output logic                                new_line,
    output logic                                new_frame,
    output logic [vga_timing_pkg::VRAM_AW-1:0]  vram_addr
);

    localparam int AW    = vga_timing_pkg::VRAM_AW;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W = $clog2(VRAM_COLS);
    localparam int ROW_W = AW - COL_W;
    localparam int HW    = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP + 1);
    localparam int VW    = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP + 1);

    if (H_VISIBLE > SCALE * VRAM_COLS) begin : g_bad_geometry
        $error("H_VISIBLE exceeds SCALE*VRAM_COLS");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [HW-1:0]    hcount;
    logic [VW-1:0]    vcount;
    logic             h_wrap, h_active, h_sync_n;
    logic             v_wrap, v_active, v_sync_n;
    logic [SUB_W-1:0] hsub, vsub;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             h_last_vis, v_last_vis;

    vga_timing_pkg::vga_out_t out_q, out_d;

    // pixel clock divider; tick is the last system clock of each pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            div_cnt <= '0;
        else if (pixel_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign pixel_tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    vga_axis_counter #(.VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_h (
        .clk(clk), .rst_n(reset), .en(pixel_tick),
        .count(hcount), .wrap(h_wrap), .active(h_active), .sync_n(h_sync_n)
    );

    vga_axis_counter #(.VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_v (
        .clk(clk), .rst_n(reset), .en(h_wrap),
        .count(vcount), .wrap(v_wrap), .active(v_active), .sync_n(v_sync_n)
    );

    // Clearing at the last visible position as well as at wrap keeps col/row
    // from running past the VRAM edge during blanking.
    assign h_last_vis = (hcount == HW'(H_VISIBLE - 1));
    assign v_last_vis = (vcount == VW'(V_VISIBLE - 1));

    // col tracks hcount/SCALE across the visible part of each line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsub <= '0;
            col  <= '0;
        end else if (pixel_tick) begin
            if (h_wrap || h_last_vis) begin
                hsub <= '0;
                col  <= '0;
            end else if (h_active) begin
                if (hsub == SUB_W'(SCALE - 1)) begin
                    hsub <= '0;
                    col  <= col + 1'b1;
                end else begin
                    hsub <= hsub + 1'b1;
                end
            end
        end
    end

    // row tracks vcount/SCALE, stepping at the end of each visible line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsub <= '0;
            row  <= '0;
        end else if (h_wrap) begin
            if (v_wrap || v_last_vis) begin
                vsub <= '0;
                row  <= '0;
            end else if (v_active) begin
                if (vsub == SUB_W'(SCALE - 1)) begin
                    vsub <= '0;
                    row  <= row + 1'b1;
                end else begin
                    vsub <= vsub + 1'b1;
                end
            end
        end
    end

    // next output bundle: decode of the current position; address frozen in blanking
    always_comb begin
        out_d           = out_q;
        out_d.hsync_n   = h_sync_n;
        out_d.vsync_n   = v_sync_n;
        out_d.new_line  = h_active;
        out_d.new_frame = v_active;
        if (h_active && v_active)
            out_d.vram_addr = {row, col};
    end

    // all registered outputs update together, one clk behind the counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_q <= vga_timing_pkg::VGA_OUT_RST;
        else
            out_q <= out_d;
    end

    assign VGA_HSYNC = out_q.hsync_n;
    assign VGA_VSYNC = out_q.vsync_n;
    assign new_line  = out_q.new_line;
    assign new_frame = out_q.new_frame;
    assign vram_addr = out_q.vram_addr;

endmodule

// File: tb/tb_vga_sync_timing_generator.sv
// Bench for vga_sync_timing_generator on a shrunken raster (same rules, short frames).
module tb_vga_sync_timing_generator;

    localparam int CD = 4;
    localparam int HV = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 15, VFP = 2, VS = 2, VBP = 3;
    localparam int SC = 5, COLS = 128;
    localparam int HT = HV + HFP + HS + HBP;   // 56
    localparam int VT = VV + VFP + VS + VBP;   // 22
    localparam int FRAME_CLKS = HT * VT * CD;  // 4928

    typedef struct packed {
        logic        tick;
        logic        hs_n;
        logic        vs_n;
        logic        nl;
        logic        nf;
        logic [13:0] addr;
    } obs_t;

    typedef struct {
        int    k;
        obs_t  exp;
        string name;
    } vec_t;

    localparam obs_t RST_OBS   = '{tick: 1'b0, hs_n: 1'b1, vs_n: 1'b1, nl: 1'b0, nf: 1'b0, addr: 14'd0};
    localparam obs_t FIRST_OBS = '{tick: 1'b0, hs_n: 1'b1, vs_n: 1'b1, nl: 1'b1, nf: 1'b1, addr: 14'd0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pixel_tick, VGA_HSYNC, VGA_VSYNC, new_line, new_frame;
    logic [13:0] vram_addr;
    obs_t        obs;

    int  k;
    int  n_vec = 0;
    int  n_bad = 0;
    bit  sb_on = 1'b0;
    vec_t vq[$];

    always #5 clk = ~clk;

    vga_sync_timing_generator #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE(SC), .VRAM_COLS(COLS)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
        .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
        .new_line(new_line), .new_frame(new_frame), .vram_addr(vram_addr)
    );

    assign obs = {pixel_tick, VGA_HSYNC, VGA_VSYNC, new_line, new_frame, vram_addr};

    // clk edges seen since reset was last released
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    // Expected outputs after kk edges: the raster position is simply the pixel
    // count (kk-1)/CD folded onto the line/frame; the address is that of the
    // most recent visible pixel.
    function automatic obs_t model(input int kk);
        obs_t e;
        int p, h, v, lh, lv;
        e = RST_OBS;
        e.tick = ((kk % CD) == CD - 1);
        if (kk == 0) return e;
        p = (kk - 1) / CD;
        h = p % HT;
        v = (p / HT) % VT;
        e.nl   = (h < HV);
        e.nf   = (v < VV);
        e.hs_n = !(h >= HV + HFP && h < HV + HFP + HS);
        e.vs_n = !(v >= VV + VFP && v < VV + VFP + VS);
        if (v >= VV) begin
            lv = VV - 1; lh = HV - 1;
        end else begin
            lv = v; lh = (h < HV) ? h : HV - 1;
        end
        e.addr = 14'((lv / SC) * COLS + lh / SC);
        return e;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got tick=%b hs=%b vs=%b nl=%b nf=%b addr=%0d want tick=%b hs=%b vs=%b nl=%b nf=%b addr=%0d",
                     name, k, act.tick, act.hs_n, act.vs_n, act.nl, act.nf, act.addr,
                     exp.tick, exp.hs_n, exp.vs_n, exp.nl, exp.nf, exp.addr);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(input int kk, input bit t, input bit hs, input bit vs, input bit nl,
                       input bit nf, input int addr, input string name);
        vec_t v;
        v.k    = kk;
        v.exp  = '{tick: t, hs_n: hs, vs_n: vs, nl: nl, nf: nf, addr: 14'(addr)};
        v.name = name;
        vq.push_back(v);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return obs.hs_n;
            1:       return obs.vs_n;
            2:       return obs.nl;
            default: return obs.nf;
        endcase
    endfunction

    // length of the next run at level lvl, and the period to the following run
    task automatic run_len(input int sel, input logic lvl, output int len, output int period);
        int g, k0;
        g = 0; len = 0;
        while (pick(sel) == lvl && g < 12000) begin @(negedge clk); g++; end
        while (pick(sel) != lvl && g < 12000) begin @(negedge clk); g++; end
        k0 = k;
        while (pick(sel) == lvl && g < 12000) begin len++; @(negedge clk); g++; end
        while (pick(sel) != lvl && g < 12000) begin @(negedge clk); g++; end
        period = k - k0;
    endtask

    // whole-output scoreboard, every clk
    always @(negedge clk) begin
        if (sb_on) check("sb", obs, model(k));
    end

    initial begin
        int len, per, g, n;

        // hand-derived checkpoints for the 56x22 raster (k = edges since release)
        add(1,    0, 1, 1, 1, 1, 0,   "first_edge");
        add(3,    1, 1, 1, 1, 1, 0,   "tick_clk4");
        add(4,    0, 1, 1, 1, 1, 0,   "no_tick_clk5");
        add(7,    1, 1, 1, 1, 1, 0,   "tick_clk8");
        add(8,    0, 1, 1, 1, 1, 0,   "no_tick_clk9");
        add(21,   0, 1, 1, 1, 1, 1,   "addr_h5");
        add(157,  0, 1, 1, 1, 1, 7,   "addr_h39");
        add(161,  0, 1, 1, 0, 1, 7,   "hblank_hold");
        add(177,  0, 0, 1, 0, 1, 7,   "hsync_first");
        add(197,  0, 0, 1, 0, 1, 7,   "hsync_last");
        add(201,  0, 1, 1, 0, 1, 7,   "hsync_off");
        add(225,  0, 1, 1, 1, 1, 0,   "line1_start");
        add(1121, 0, 1, 1, 1, 1, 128, "row1_start");
        add(3293, 0, 1, 1, 1, 1, 263, "last_visible");
        add(3297, 0, 1, 1, 0, 1, 263, "last_line_hblank");
        add(3361, 0, 1, 1, 1, 0, 263, "vblank_hold");
        add(3809, 0, 1, 0, 1, 0, 263, "vsync_first");
        add(4253, 0, 1, 0, 0, 0, 263, "vsync_last");
        add(4257, 0, 1, 1, 1, 0, 263, "vsync_off");
        add(4929, 0, 1, 1, 1, 1, 0,   "frame_wrap");

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", obs, RST_OBS);

        reset = 1'b1;
        sb_on = 1'b1;
        foreach (vq[i]) begin
            g = 0;
            while (k < vq[i].k && g < 20000) begin @(negedge clk); g++; end
            check(vq[i].name, obs, vq[i].exp);
        end

        // sync / active run lengths and periods, in clks
        run_len(0, 1'b0, len, per);
        check_int("hsync_low_clks", len, HS * CD);
        check_int("line_period", per, HT * CD);
        run_len(2, 1'b1, len, per);
        check_int("new_line_high_clks", len, HV * CD);
        check_int("new_line_period", per, HT * CD);
        run_len(1, 1'b0, len, per);
        check_int("vsync_low_clks", len, VS * HT * CD);
        check_int("frame_period", per, FRAME_CLKS);
        run_len(3, 1'b1, len, per);
        check_int("new_frame_high_clks", len, VV * HT * CD);

        // reset mid-line at (20,10): immediate, no edge needed
        g = 0;
        while (!((((k - 1) / CD) % HT == 20) && ((((k - 1) / CD) / HT) % VT == 10)) && g < 6000) begin
            @(negedge clk); g++;
        end
        check_int("reach_20_10", g < 6000, 1);
        #2 reset = 1'b0;
        #1 check("async_reset", obs, RST_OBS);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart", obs, FIRST_OBS);

        // reset at random points in the frame
        repeat (3) begin
            n = $urandom_range(1, 2500);
            repeat (n) @(negedge clk);
            #2 reset = 1'b0;
            #1 check("rand_async_reset", obs, RST_OBS);
            n = $urandom_range(1, 5);
            repeat (n) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("rand_restart", obs, FIRST_OBS);
        end

        // free run, scoreboard only
        repeat (3 * FRAME_CLKS) @(negedge clk);
        sb_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
